// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_xfer_ctrl
//  Description : Shared-bus register transfer sequencer. A request names one
//                bus source (register A, B, X or an 8-bit immediate) and a
//                load mask (A, B, X, Q). The block drives the source onto the
//                bus, lets the bus settle for SETTLE_CYCLES cycles, pulses the
//                load strobes once, then reports completion. All outputs are
//                registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_xfer_ctrl #(
   // Number of DRIVE cycles before the load strobe; legal range 1..15.
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   // request channel
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_src,
   input  logic [3:0] req_dst,
   input  logic [7:0] req_imm,
   // active-low bus-drive enables
   output logic       assertBarA,
   output logic       assertBarB,
   output logic       assertBarX,
   // active-high one-cycle load strobes
   output logic       triggerA,
   output logic       triggerB,
   output logic       triggerX,
   output logic       triggerQ,
   // immediate data path onto the shared bus
   output logic [7:0] dbus_out,
   output logic       dbus_oe,
   // status
   output logic       done,
   output logic       err,
   output logic [7:0] xfer_count
);

   // Source encodings
   localparam logic [2:0] c_srcA   = 3'd0;
   localparam logic [2:0] c_srcB   = 3'd1;
   localparam logic [2:0] c_srcX   = 3'd2;
   localparam logic [2:0] c_srcImm = 3'd3;

   // Last DRIVE-cycle count value; the counter starts at 1 on acceptance.
   localparam logic [3:0] c_settleLast = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_LOAD  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t     r_state;
   logic [3:0] r_settleCnt;
   logic [2:0] r_src;
   logic [3:0] r_dst;
   logic [7:0] r_imm;

   // Decode a source code into {immediate-oe, selX, selB, selA}; at most one
   // bit is ever set, and invalid codes select nothing.
   function automatic logic [3:0] srcSelect(input logic [2:0] src);
      logic [3:0] sel;
      sel = 4'b0000;
      case (src)
         c_srcA:   sel = 4'b0001;
         c_srcB:   sel = 4'b0010;
         c_srcX:   sel = 4'b0100;
         c_srcImm: sel = 4'b1000;
         default:  sel = 4'b0000;
      endcase
      return sel;
   endfunction

   // Only codes 0..3 name a bus source.
   function automatic logic srcIsValid(input logic [2:0] src);
      return (src[2] == 1'b0);
   endfunction

   // Sequencer: state, captured request, settle counter and every output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_settleCnt <= 4'd0;
         r_src       <= 3'd0;
         r_dst       <= 4'd0;
         r_imm       <= 8'd0;
         req_ready   <= 1'b1;
         assertBarA  <= 1'b1;
         assertBarB  <= 1'b1;
         assertBarX  <= 1'b1;
         triggerA    <= 1'b0;
         triggerB    <= 1'b0;
         triggerX    <= 1'b0;
         triggerQ    <= 1'b0;
         dbus_out    <= 8'd0;
         dbus_oe     <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         xfer_count  <= 8'd0;
      end else begin
         // Pulse outputs default low; each state raises only what it owns.
         triggerA <= 1'b0;
         triggerB <= 1'b0;
         triggerX <= 1'b0;
         triggerQ <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_src <= req_src;
                  r_dst <= req_dst;
                  r_imm <= req_imm;
                  if (srcIsValid(req_src)) begin
                     // Enables come straight from the request so the source
                     // is on the bus in the very first DRIVE cycle.
                     r_state     <= ST_DRIVE;
                     r_settleCnt <= 4'd1;
                     req_ready   <= 1'b0;
                     assertBarA  <= ~srcSelect(req_src)[0];
                     assertBarB  <= ~srcSelect(req_src)[1];
                     assertBarX  <= ~srcSelect(req_src)[2];
                     dbus_oe     <= srcSelect(req_src)[3];
                     dbus_out    <= srcSelect(req_src)[3] ? req_imm : 8'd0;
                  end else begin
                     // Rejected: stay idle, flag it, touch nothing else.
                     err <= 1'b1;
                  end
               end
            end

            ST_DRIVE: begin
               // Keep the captured source on the bus while it settles.
               assertBarA <= ~srcSelect(r_src)[0];
               assertBarB <= ~srcSelect(r_src)[1];
               assertBarX <= ~srcSelect(r_src)[2];
               dbus_oe    <= srcSelect(r_src)[3];
               dbus_out   <= srcSelect(r_src)[3] ? r_imm : 8'd0;
               if (r_settleCnt >= c_settleLast) begin
                  r_state     <= ST_LOAD;
                  r_settleCnt <= 4'd0;
                  triggerA    <= r_dst[0];
                  triggerB    <= r_dst[1];
                  triggerX    <= r_dst[2];
                  triggerQ    <= r_dst[3];
               end else begin
                  r_settleCnt <= r_settleCnt + 4'd1;
               end
            end

            ST_LOAD: begin
               // Source still held through the hold cycle after the strobe.
               r_state    <= ST_HOLD;
               done       <= 1'b1;
               xfer_count <= xfer_count + 8'd1;
            end

            ST_HOLD: begin
               // Release the bus and reopen the request channel.
               r_state    <= ST_IDLE;
               req_ready  <= 1'b1;
               assertBarA <= 1'b1;
               assertBarB <= 1'b1;
               assertBarX <= 1'b1;
               dbus_oe    <= 1'b0;
               dbus_out   <= 8'd0;
            end

            default: begin
               r_state    <= ST_IDLE;
               req_ready  <= 1'b1;
               assertBarA <= 1'b1;
               assertBarB <= 1'b1;
               assertBarX <= 1'b1;
               dbus_oe    <= 1'b0;
               dbus_out   <= 8'd0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_xfer_ctrl
//  Description : Directed self-checking bench for bus_xfer_ctrl with one
//                instance at SETTLE_CYCLES=1 and one at SETTLE_CYCLES=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_xfer_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nAsserts = 0;
   int nFails   = 0;

   // ---- instance with SETTLE_CYCLES = 1 ----
   logic       reset1 = 1'b1, valid1 = 1'b0;
   logic [2:0] src1 = 3'd0;
   logic [3:0] dst1 = 4'd0;
   logic [7:0] imm1 = 8'd0;
   logic       ready1, barA1, barB1, barX1, tA1, tB1, tX1, tQ1, oe1, done1, err1;
   logic [7:0] dout1, cnt1;

   bus_xfer_ctrl #(.SETTLE_CYCLES(1)) u_dutS1 (
      .clk(clk), .reset(reset1), .req_valid(valid1), .req_ready(ready1),
      .req_src(src1), .req_dst(dst1), .req_imm(imm1),
      .assertBarA(barA1), .assertBarB(barB1), .assertBarX(barX1),
      .triggerA(tA1), .triggerB(tB1), .triggerX(tX1), .triggerQ(tQ1),
      .dbus_out(dout1), .dbus_oe(oe1), .done(done1), .err(err1),
      .xfer_count(cnt1)
   );

   // ---- instance with SETTLE_CYCLES = 3 ----
   logic       reset3 = 1'b1, valid3 = 1'b0;
   logic [2:0] src3 = 3'd0;
   logic [3:0] dst3 = 4'd0;
   logic [7:0] imm3 = 8'd0;
   logic       ready3, barA3, barB3, barX3, tA3, tB3, tX3, tQ3, oe3, done3, err3;
   logic [7:0] dout3, cnt3;

   bus_xfer_ctrl #(.SETTLE_CYCLES(3)) u_dutS3 (
      .clk(clk), .reset(reset3), .req_valid(valid3), .req_ready(ready3),
      .req_src(src3), .req_dst(dst3), .req_imm(imm3),
      .assertBarA(barA3), .assertBarB(barB3), .assertBarX(barX3),
      .triggerA(tA3), .triggerB(tB3), .triggerX(tX3), .triggerQ(tQ3),
      .dbus_out(dout3), .dbus_oe(oe3), .done(done3), .err(err3),
      .xfer_count(cnt3)
   );

   // Status word: {ready, barA, barB, barX, trig[Q,X,B,A], oe, done, err}
   function automatic logic [10:0] pk(input logic rdy, input logic bA, input logic bB,
                                      input logic bX, input logic [3:0] tr,
                                      input logic oe, input logic dn, input logic er);
      return {rdy, bA, bB, bX, tr, oe, dn, er};
   endfunction

   logic [10:0] obs1, obs3;
   assign obs1 = {ready1, barA1, barB1, barX1, tQ1, tX1, tB1, tA1, oe1, done1, err1};
   assign obs3 = {ready3, barA3, barB3, barX3, tQ3, tX3, tB3, tA3, oe3, done3, err3};

   localparam logic [10:0] c_idle = 11'b1_111_0000_000;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int dones, accepts, lastAccept, spacingErr, multiEn;

   initial begin
      #1;
      step(); step();
      reset1 = 1'b0; reset3 = 1'b0;
      step();
      checkVal("rst_status1", 32'(obs1), 32'(c_idle));
      checkVal("rst_count1",  32'(cnt1), 32'd0);
      checkVal("rst_dout1",   32'(dout1), 32'd0);
      checkVal("rst_status3", 32'(obs3), 32'(c_idle));

      // ---- A -> Q, S=1; inputs scrambled after acceptance ----
      valid1 = 1'b1; src1 = 3'd0; dst1 = 4'b1000; imm1 = 8'h00;
      step();
      valid1 = 1'b0; src1 = 3'd7; dst1 = 4'hF; imm1 = 8'hFF;
      checkVal("aq_c1", 32'(obs1), 32'(pk(0,0,1,1,4'b0000,0,0,0))); step();
      checkVal("aq_c2", 32'(obs1), 32'(pk(0,0,1,1,4'b1000,0,0,0))); step();
      checkVal("aq_c3", 32'(obs1), 32'(pk(0,0,1,1,4'b0000,0,1,0)));
      checkVal("aq_cnt", 32'(cnt1), 32'd1); step();
      checkVal("aq_c4", 32'(obs1), 32'(c_idle));

      // ---- immediate 5A -> A,B,X ----
      valid1 = 1'b1; src1 = 3'd3; dst1 = 4'b0111; imm1 = 8'h5A;
      step();
      valid1 = 1'b0; src1 = 3'd0; imm1 = 8'h00; dst1 = 4'b0000;
      checkVal("imm_c1", 32'(obs1), 32'(pk(0,1,1,1,4'b0000,1,0,0)));
      checkVal("imm_d1", 32'(dout1), 32'h5A); step();
      checkVal("imm_c2", 32'(obs1), 32'(pk(0,1,1,1,4'b0111,1,0,0)));
      checkVal("imm_d2", 32'(dout1), 32'h5A); step();
      checkVal("imm_c3", 32'(obs1), 32'(pk(0,1,1,1,4'b0000,1,1,0)));
      checkVal("imm_d3", 32'(dout1), 32'h5A); step();
      checkVal("imm_c4", 32'(obs1), 32'(c_idle));
      checkVal("imm_d4", 32'(dout1), 32'h00);
      checkVal("imm_cnt", 32'(cnt1), 32'd2);

      // ---- invalid source 5 ----
      valid1 = 1'b1; src1 = 3'd5; dst1 = 4'hF; imm1 = 8'hAA;
      step();
      valid1 = 1'b0;
      checkVal("inv_c1", 32'(obs1), 32'(pk(1,1,1,1,4'b0000,0,0,1)));
      checkVal("inv_d1", 32'(dout1), 32'h00); step();
      checkVal("inv_c2", 32'(obs1), 32'(c_idle));
      checkVal("inv_cnt", 32'(cnt1), 32'd2);

      // ---- X with empty load mask ----
      valid1 = 1'b1; src1 = 3'd2; dst1 = 4'b0000;
      step();
      valid1 = 1'b0;
      checkVal("nod_c1", 32'(obs1), 32'(pk(0,1,1,0,4'b0000,0,0,0))); step();
      checkVal("nod_c2", 32'(obs1), 32'(pk(0,1,1,0,4'b0000,0,0,0))); step();
      checkVal("nod_c3", 32'(obs1), 32'(pk(0,1,1,0,4'b0000,0,1,0)));
      checkVal("nod_cnt", 32'(cnt1), 32'd3); step();

      // ---- A -> A ----
      valid1 = 1'b1; src1 = 3'd0; dst1 = 4'b0001;
      step();
      valid1 = 1'b0;
      step();
      checkVal("aa_c2", 32'(obs1), 32'(pk(0,0,1,1,4'b0001,0,0,0))); step();
      checkVal("aa_cnt", 32'(cnt1), 32'd4); step();
      checkVal("aa_c4", 32'(obs1), 32'(c_idle));

      // ---- reset beats a simultaneous request ----
      valid1 = 1'b1; src1 = 3'd1; dst1 = 4'b0010; reset1 = 1'b1;
      step();
      valid1 = 1'b0; reset1 = 1'b0;
      checkVal("rpri_status", 32'(obs1), 32'(c_idle));
      checkVal("rpri_cnt",    32'(cnt1), 32'd0);
      step();
      checkVal("rpri_next",   32'(obs1), 32'(c_idle));

      // ---- S=3: reset in the middle of a B -> B transfer ----
      valid3 = 1'b1; src3 = 3'd1; dst3 = 4'b0010;
      step();
      valid3 = 1'b0;
      checkVal("mr_c1", 32'(obs3), 32'(pk(0,1,0,1,4'b0000,0,0,0))); step();
      checkVal("mr_c2", 32'(obs3), 32'(pk(0,1,0,1,4'b0000,0,0,0)));
      reset3 = 1'b1;
      step();
      reset3 = 1'b0;
      checkVal("mr_c3", 32'(obs3), 32'(c_idle));
      checkVal("mr_cnt", 32'(cnt3), 32'd0); step();
      checkVal("mr_c4", 32'(obs3), 32'(c_idle)); step();
      checkVal("mr_c5", 32'(obs3), 32'(c_idle));
      checkVal("mr_cnt2", 32'(cnt3), 32'd0);

      // ---- S=3: full X -> A latency ----
      valid3 = 1'b1; src3 = 3'd2; dst3 = 4'b0001;
      step();
      valid3 = 1'b0;
      checkVal("s3_c1", 32'(obs3), 32'(pk(0,1,1,0,4'b0000,0,0,0))); step();
      checkVal("s3_c2", 32'(obs3), 32'(pk(0,1,1,0,4'b0000,0,0,0))); step();
      checkVal("s3_c3", 32'(obs3), 32'(pk(0,1,1,0,4'b0000,0,0,0))); step();
      checkVal("s3_c4", 32'(obs3), 32'(pk(0,1,1,0,4'b0001,0,0,0))); step();
      checkVal("s3_c5", 32'(obs3), 32'(pk(0,1,1,0,4'b0000,0,1,0)));
      checkVal("s3_cnt", 32'(cnt3), 32'd1); step();
      checkVal("s3_c6", 32'(obs3), 32'(c_idle));

      // ---- S=1: 256 back-to-back transfers with req_valid held ----
      reset1 = 1'b1;
      step();
      reset1 = 1'b0;
      src1 = 3'd1; dst1 = 4'b0010; valid1 = 1'b1;
      dones = 0; accepts = 0; lastAccept = -4; spacingErr = 0; multiEn = 0;
      for (int i = 0; i < 1040; i++) begin
         if (int'(!barA1) + int'(!barB1) + int'(!barX1) + int'(oe1) > 1) multiEn++;
         if (done1) dones++;
         if (ready1 && valid1) begin
            accepts++;
            if (i - lastAccept != 4) spacingErr++;
            lastAccept = i;
         end
         step();
         if (accepts == 256) valid1 = 1'b0;
      end
      checkVal("b2b_accepts", 32'(accepts), 32'd256);
      checkVal("b2b_spacing", 32'(spacingErr), 32'd0);
      checkVal("b2b_dones",   32'(dones), 32'd256);
      checkVal("b2b_multien", 32'(multiEn), 32'd0);
      checkVal("b2b_cnt",     32'(cnt1), 32'd0);
      checkVal("b2b_idle",    32'(obs1), 32'(c_idle));

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 1, number of DRIVE cycles before the load strobe; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  transfer request present.
REQ-005 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 req_src  input  3  bus source: 0=A, 1=B, 2=X, 3=immediate, 4..7 invalid.
REQ-007 req_dst  input  4  load mask, bit0=A, bit1=B, bit2=X, bit3=Q; any combination legal.
REQ-008 req_imm  input  8  immediate value, used when req_src=3.
REQ-009 assertBarA, assertBarB, assertBarX  output  1 each  active-low register bus-drive enables.
REQ-010 triggerA, triggerB, triggerX, triggerQ  output  1 each  active-high one-cycle register load strobes.
REQ-011 dbus_out  output  8  immediate data to the shared bus.
REQ-012 dbus_oe  output  1  high when dbus_out drives the bus.
REQ-013 done  output  1  one-cycle pulse when a transfer completes.
REQ-014 err  output  1  one-cycle pulse when an invalid request is rejected.
REQ-015 xfer_count  output  8  completed-transfer count.

Function
REQ-016 Acceptance occurs on a cycle with req_valid=1 and req_ready=1; req_src, req_dst and req_imm SHALL be captured into internal registers at that edge; later input changes have no effect.
REQ-017 States: IDLE, DRIVE, LOAD, HOLD; all outputs SHALL be registered (decoded from state and captured request).
REQ-018 IDLE: req_ready=1, all assertBar*=1, all trigger*=0, dbus_oe=0; accepted valid src -> DRIVE; accepted invalid src -> ERR handling (REQ-024).
REQ-019 DRIVE: selected source enable active (assertBar of src = 0, or dbus_oe=1 with dbus_out=captured imm for src 3); a settle counter runs SETTLE_CYCLES cycles, then -> LOAD.
REQ-020 LOAD: source enable held; trigger* = captured req_dst for exactly one cycle; -> HOLD.
REQ-021 HOLD: source enable held, triggers 0, done=1, xfer_count increments; -> IDLE.
REQ-022 At most one source enable SHALL be active in any cycle; no enable or trigger is active in IDLE.
REQ-023 Latency with SETTLE_CYCLES=S: accept at edge 0; DRIVE cycles 1..S; LOAD cycle S+1; HOLD/done cycle S+2; req_ready high cycle S+3; throughput one transfer per S+3 cycles.
REQ-024 Invalid src (4..7): err=1 in the cycle after acceptance, state remains IDLE, no enables, triggers, done or count change.
REQ-025 req_dst=0: full sequence runs, no triggers, done pulses, count increments.
REQ-026 Source also in req_dst (e.g. A->A): legal; trigger of that register pulses while its assertBar is low.
REQ-027 xfer_count SHALL wrap 255 -> 0.
REQ-028 dbus_out SHALL be 0 whenever dbus_oe=0.

Reset
REQ-029 reset=1 at an edge SHALL force state IDLE, assertBar*=1, trigger*=0, dbus_oe=0, dbus_out=0, done=0, err=0, xfer_count=0, settle counter 0, from any state including mid-transfer; reset has priority over acceptance.
REQ-030 First acceptance possible at the first edge with reset=0; req_ready=1 in the cycle following reset release.

Verification
REQ-031 S=1, src=0, dst=4'b1000 -> assertBarA low cycles 1-3, triggerQ high cycle 2 only, done cycle 3, xfer_count=1, ready cycle 4.
REQ-032 S=1, src=3, imm=8'h5A, dst=4'b0111 -> dbus_oe=1 and dbus_out=8'h5A cycles 1-3, triggerA/B/X high cycle 2, no assertBar low.
REQ-033 src=5 -> err pulse cycle 1, no enable/trigger/done, xfer_count unchanged, ready stays 1.
REQ-034 S=3, src=1, dst=4'b0010 with reset asserted in cycle 2 -> all outputs idle next cycle, no triggerB, no done, xfer_count=0.
REQ-035 req_valid held high for 256 back-to-back transfers (S=1) -> accept every 4 cycles, done 256 times, xfer_count returns to 0, never two enables low together.
